alu_serial_seq: RTL and testbench

//  Bit-serial sequencer driving a single alu1 slice. Latches WIDTH-bit operands
//  and a 3-bit select, then feeds the slice LSB first, one bit per clock.

---
 rtl/alu_serial_seq.sv | 135 +++++++++++++
 tb/tb_alu_serial_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one alu1 slice processes WIDTH-bit operands LSB first,
// one bit per clock, with the slice carry registered and fed back into the next bit.

module alu1 (
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [2:0] select,
    output logic       out,
    output logic       carry_out
);
    // Arithmetic B operand: 0=b (add), 1=~b (subtract), 2=0 (pass/increment), 3=1 (decrement)
    logic b_op;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        out       = 1'b0;
        carry_out = carry_in;
        b_op      = 1'b0;
        if (!select[2]) begin
            // Logic unit passes the carry straight through so the chain stays intact.
            unique case (select[1:0])
                2'd0: out = ~a;
                2'd1: out = a ^ b;
                2'd2: out = a | b;
                2'd3: out = a & b;
            endcase
        end else begin
            unique case (select[1:0])
                2'd0: b_op = b;
                2'd1: b_op = ~b;
                2'd2: b_op = 1'b0;
                2'd3: b_op = 1'b1;
            endcase
            out       = a ^ b_op ^ carry_in;
            carry_out = (a & b_op) | (a & carry_in) | (b_op & carry_in);
        end
    end
endmodule

module alu_serial_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       select,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [CW-1:0]    count;
    logic [2:0]       sel_q;
    logic             cry_q;
    logic             bit_out;
    logic             bit_carry;
    logic             last_bit;
    logic             accept;

    alu1 u_alu1 (
        .a        (a_sh[0]),
        .b        (b_sh[0]),
        .carry_in (cry_q),
        .select   (sel_q),
        .out      (bit_out),
        .carry_out(bit_carry)
    );

    assign ready    = (state != RUN);
    assign done     = (state == DONE);
    assign accept   = ready && start;
    assign last_bit = (count == CW'(WIDTH - 1));

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (start) next_state = RUN;
            RUN:  if (last_bit) next_state = DONE;
            DONE: next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            count     <= '0;
            sel_q     <= '0;
            cry_q     <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                sel_q <= select;
                cry_q <= carry_in;
                count <= '0;
            end else if (state == RUN) begin
                res_sh <= {bit_out, res_sh[WIDTH-1:1]};
                cry_q  <= bit_carry;
                a_sh   <= a_sh >> 1;
                b_sh   <= b_sh >> 1;
                count  <= count + CW'(1);
                // Publish the full word only on the final bit so result never shows partial values.
                if (last_bit) begin
                    result    <= {bit_out, res_sh[WIDTH-1:1]};
                    carry_out <= bit_carry;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: driver pushes word-level expected results,
// a negedge monitor pops and compares on every done pulse.

module tb_alu_serial_seq;
    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   select;
    logic         carry_in;
    logic [W-1:0] result;
    logic         carry_out;
    logic         done;

    exp_t         sb[$];
    int           done_cycles[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [W-1:0] last_res = '0;
    logic         last_co = 1'b0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ready    (ready),
        .a        (a),
        .b        (b),
        .select   (select),
        .carry_in (carry_in),
        .result   (result),
        .carry_out(carry_out),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Word-level reference: logic ops bitwise with carry passed through,
    // arithmetic ops as a + B' + cin on W+1 bits.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic [2:0] sel, input logic cin);
        exp_t         e;
        logic [W-1:0] bop;
        logic [W:0]   sum;
        if (!sel[2]) begin
            case (sel[1:0])
                2'd0: e.res = ~av;
                2'd1: e.res = av ^ bv;
                2'd2: e.res = av | bv;
                default: e.res = av & bv;
            endcase
            e.co = cin;
        end else begin
            case (sel[1:0])
                2'd0: bop = bv;
                2'd1: bop = ~bv;
                2'd2: bop = '0;
                default: bop = '1;
            endcase
            sum   = {1'b0, av} + {1'b0, bop} + (W + 1)'(cin);
            e.res = sum[W-1:0];
            e.co  = sum[W];
        end
        return e;
    endfunction

    // Monitor: compare on done, and require result/carry_out to hold between done pulses.
    always @(negedge clk) begin
        if (reset) begin
            last_res = '0;
            last_co  = 1'b0;
        end else if (done) begin
            done_cycles.push_back(cyc);
            if (sb.size() == 0) begin
                check("done_with_empty_scoreboard", done, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("carry_out", carry_out, e.co);
            end
            last_res = result;
            last_co  = carry_out;
        end else begin
            check("result_hold", result, last_res);
            check("carry_hold", carry_out, last_co);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", ready, 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // Issues one op at a negedge; returns at the negedge after acceptance with inputs scrambled.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2:0] sel, input logic cin, input bit hold);
        wait_ready();
        a        = av;
        b        = bv;
        select   = sel;
        carry_in = cin;
        start    = 1'b1;
        sb.push_back(model(av, bv, sel, cin));
        @(negedge clk);
        if (!hold) start = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        select   = 3'($urandom);
        carry_in = 1'($urandom);
    endtask

    initial begin
        int c0;
        int nd;
        reset    = 1'b1;
        start    = 1'b1;
        a        = '1;
        b        = '1;
        select   = 3'b100;
        carry_in = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_carry", carry_out, 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("idle_done", done, 0);

        // Directed logic ops
        c0 = cyc;
        do_op(4'b1100, 4'b1010, 3'b011, 1'b0, 1'b0);
        drain();
        check("logic_latency", done_cycles[$] - c0, W + 1);
        do_op(4'b1100, 4'b1010, 3'b001, 1'b0, 1'b0);
        do_op(4'b1100, 4'b1010, 3'b000, 1'b1, 1'b0);
        drain();

        // Exhaustive arithmetic
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int s = 0; s < 4; s++)
                    for (int ci = 0; ci < 2; ci++)
                        do_op(W'(ai), W'(bi), {1'b1, 2'(s)}, 1'(ci), 1'b0);
        drain();

        // Back-to-back with start held high
        repeat (3) @(negedge clk);
        done_cycles.delete();
        for (int i = 0; i < 3; i++)
            do_op(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom), 1'b1);
        start = 1'b0;
        drain();
        check("b2b_count", done_cycles.size(), 3);
        if (done_cycles.size() == 3) begin
            check("b2b_gap1", done_cycles[1] - done_cycles[0], W + 1);
            check("b2b_gap2", done_cycles[2] - done_cycles[1], W + 1);
        end

        // Start pulsed during RUN cycle 2 is ignored
        nd = done_cycles.size();
        do_op(4'b0111, 4'b0101, 3'b100, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 4'b1111;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("ignored_start_dones", done_cycles.size() - nd, 1);

        // Reset mid-op
        do_op(4'b1001, 4'b0011, 3'b101, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        check("midreset_result", result, 0);
        check("midreset_carry", carry_out, 0);
        check("midreset_ready", ready, 1);
        nd = done_cycles.size();
        repeat (8) @(negedge clk);
        check("midreset_no_done", done_cycles.size() - nd, 0);
        c0 = cyc;
        do_op(4'b1001, 4'b0011, 3'b101, 1'b1, 1'b0);
        drain();
        check("post_reset_latency", done_cycles[$] - c0, W + 1);

        // Random ops with random gaps and holds
        for (int i = 0; i < 200; i++) begin
            bit h;
            h = 1'($urandom);
            do_op(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom), h);
            if (h) start = 1'b0;
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
